// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared types and constants for the 4-way round-robin mux arbiter.
// Holds the FSM state encoding, requester count and the select width.
package mux4_rr_arbiter_pkg;

  localparam int N_REQ  = 4;
  localparam int ADDR_W = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  function automatic logic [N_REQ-1:0] onehot(input logic [ADDR_W-1:0] a);
    onehot = N_REQ'(1) << a;
  endfunction

endpackage

// File: rtl/mux4_rr_arbiter_if.sv
// Request/grant bundle between the four requesters and the arbiter.
// The arbiter uses the slave modport; the requester side uses master.
interface mux4_rr_arbiter_if;
  import mux4_rr_arbiter_pkg::*;

  logic [N_REQ-1:0]  Req;
  logic [N_REQ-1:0]  Grant;
  logic [ADDR_W-1:0] Address;
  logic              Valid;

  modport master (output Req, input Grant, input Address, input Valid);
  modport slave  (input Req, output Grant, output Address, output Valid);

endinterface

// File: rtl/rr_pick4.sv
// Combinational circular search: first set request after i_last, wrapping.
// Zero latency; no backpressure, o_found flags that any request is set.
module rr_pick4
  import mux4_rr_arbiter_pkg::*;
(
  input  logic [N_REQ-1:0]  i_req,
  input  logic [ADDR_W-1:0] i_last,
  output logic [ADDR_W-1:0] o_idx,
  output logic              o_found
);

  logic [2*N_REQ-1:0] w_dbl;
  logic [ADDR_W:0]    w_start;
  logic [N_REQ-1:0]   w_rot;
  logic [ADDR_W-1:0]  w_off;

  // Rotating a doubled copy puts index last+1 at bit 0 of w_rot.
  assign w_dbl   = {i_req, i_req};
  assign w_start = {1'b0, i_last} + 3'd1;
  assign w_rot   = w_dbl[w_start +: N_REQ];

  always_comb begin
    w_off = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (w_rot[k]) w_off = ADDR_W'(k);
    end
  end

  assign o_idx   = i_last + 2'd1 + w_off;
  assign o_found = |i_req;

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin owner selection for a shared 4:1 mux with bounded hold time.
// Req to Grant is one clock; a release hands over with no idle bubble.
module mux4_rr_arbiter
  import mux4_rr_arbiter_pkg::*;
#(
  parameter int HOLD_MAX = 8,
  parameter int CNT_W    = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  mux4_rr_arbiter_if.slave        bus
);

  localparam logic [CNT_W-1:0] HOLD_C = CNT_W'(HOLD_MAX);

  state_t              r_state;
  logic [N_REQ-1:0]    r_grant;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_valid;
  logic [CNT_W-1:0]    r_cnt;
  logic [ADDR_W-1:0]   r_last;

  logic [ADDR_W-1:0]   w_idx;
  logic                w_found;
  logic [N_REQ-1:0]    w_mreq;
  logic [ADDR_W-1:0]   w_midx;
  logic                w_mfound;
  logic                w_own;

  rr_pick4 u_pick (
    .i_req   (bus.Req),
    .i_last  (r_last),
    .o_idx   (w_idx),
    .o_found (w_found)
  );

  // Owner is masked out so a handover never re-picks the current owner.
  assign w_mreq = bus.Req & ~onehot(r_addr);

  rr_pick4 u_mpick (
    .i_req   (w_mreq),
    .i_last  (r_last),
    .o_idx   (w_midx),
    .o_found (w_mfound)
  );

  assign w_own = bus.Req[r_addr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_grant <= '0;
      r_addr  <= '0;
      r_valid <= 1'b0;
      r_cnt   <= '0;
      r_last  <= 2'd3;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_state <= ST_GRANT;
            r_grant <= onehot(w_idx);
            r_addr  <= w_idx;
            r_valid <= 1'b1;
            r_cnt   <= CNT_W'(1);
            r_last  <= w_idx;
          end
        end
        ST_GRANT: begin
          if ((!w_own || r_cnt >= HOLD_C) && w_mfound) begin
            r_grant <= onehot(w_midx);
            r_addr  <= w_midx;
            r_cnt   <= CNT_W'(1);
            r_last  <= w_midx;
          end else if (!w_own) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
            r_valid <= 1'b0;
            r_cnt   <= '0;
          end else if (r_cnt < HOLD_C) begin
            r_cnt   <= r_cnt + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.Grant   = r_grant;
  assign bus.Address = r_addr;
  assign bus.Valid   = r_valid;

endmodule

// File: doc/mux4_rr_arbiter.md
Name: mux4_rr_arbiter

Overview:
- Round-robin arbiter that shares one 4:1 one-bit multiplexer among four requesters.
- Drives the mux select (Address) and a one-hot grant vector. Gives fair access and bounded hold time.
- Sits in front of the multiplexer4 datapath. Address connects directly to the mux Address input. Requester i owns mux input X[i].

Parameters:
- HOLD_MAX, 8, maximum consecutive cycles one owner keeps the grant while any other request is pending. Legal range 1..255.
- CNT_W, 8, hold counter width. Must satisfy 2**CNT_W > HOLD_MAX.

Ports:
- clk  input  1  single system clock, rising-edge active.
- rst_n  input  1  reset, asynchronous, active-low.
- Req  input  4  request per requester. Requester i asserts Req[i] and holds it high while it needs the mux.
- Grant  output  4  one-hot registered grant; all zero when nobody owns the mux.
- Address  output  2  registered mux select, equal to the binary index of the current owner.
- Valid  output  1  high while Grant is non-zero.

Behaviour:
- Reset (asynchronous, rst_n low) forces, without waiting for a clock edge:
  - state = IDLE, Grant = 4'b0000, Address = 2'b00, Valid = 0;
  - hold counter = 0, priority pointer last = 2'd3, so requester 0 has top priority after reset.
- Reset released mid-operation: first grant decision happens on the first rising edge with rst_n high.
- Pick function (combinational):
  - circular search of Req starting at index last+1 (mod 4) and ending at index last;
  - result is the first set bit, plus found = |Req.
- State IDLE:
  - found = 0: stay in IDLE, outputs unchanged.
  - found = 1: on the next edge go to GRANT, Grant = onehot(pick), Address = pick, Valid = 1, counter = 1, last = pick.
  - Latency from Req to Grant is one clock.
- State GRANT, owner o = Address:
  - Release: Req[o] = 0 and another request pending. Next edge grants pick(Req with bit o masked), counter = 1, last updated. No bubble; Valid stays 1.
  - Release with no other request pending: next edge returns to IDLE, Grant = 0, Valid = 0. Address keeps its last value; it is don't-care for the mux.
  - Preempt: Req[o] = 1, counter == HOLD_MAX and another request pending. Next edge grants the next requester by the pick rule, excluding o. Counter = 1.
  - Hold: Req[o] = 1 and (counter < HOLD_MAX or no other request). Grant is held. Counter increments and saturates at HOLD_MAX. A sole requester is never dropped.
- Invariants:
  - Grant is always zero or one-hot.
  - Valid == |Grant.
  - When Valid = 1, Grant[Address] == 1.
  - Address and Grant change only on rising clk edges, except under reset.
- Simultaneous events:
  - requests that arrive in the same cycle as a release are considered in that same decision;
  - ties are broken only by the round-robin order.
- Fairness: any continuously asserted Req is granted within 3*HOLD_MAX + 3 cycles.
- Counter arithmetic is unsigned, CNT_W bits. A saturating compare prevents wrap-around.

Decomposition:
- Shared include/package holds:
  - state encodings ST_IDLE = 1'b0, ST_GRANT = 1'b1;
  - N_REQ = 4;
  - ADDR_W = 2.
- One natural sub-module: rr_pick4. It is purely combinational, with inputs Req[3:0] and last[1:0] and outputs idx[1:0] and found. It is reused for both the normal pick and the masked pick.

Test Plan:
1. Reset, then Req = 4'b0001 at edge k → at edge k+1 Grant = 0001, Address = 00, Valid = 1.
2. HOLD_MAX = 4, Req = 4'b1111 held → Address sequence 0,1,2,3,0, each held exactly 4 cycles, Valid never drops.
3. Only Req[2] held for 20 cycles → Grant stays 0100 and Address stays 10 throughout; counter saturates.
4. Owner 1 drops Req[1] while Req[3] is high → next edge Grant = 1000, Address = 11, no Valid gap.
5. All requests drop while owner is 3 → next edge Grant = 0000, Valid = 0, Address stays 11. Then Req = 4'b1001 → Grant = 0001 (pointer after 3 wraps to 0).
6. rst_n pulled low mid-grant between edges → Grant, Valid and Address are 0 immediately. After release, Req = 4'b1111 → first Grant = 0001.
